vedacao_multicanal: RTL and testbench
=====================================

Name: vedacao_multicanal

Overview:
- Parametrised successor to the single-head sealing FSM.
- Drives N_CH independent sealing heads from one shared cork magazine.
- Each head has a multi-cycle seal pulse, a done pulse, a wait-for-bottle-exit interlock and an alarm state.
- Magazine corks are tracked by a counter with reload, low-level flag and fixed-priority grant. Sits between the conveyor position sensors and the sealing actuators.

Parameters:
N_CH, 2, number of sealing heads/channels
SEAL_CYCLES, 3, cycles ve[i] stays high per seal (>=1)
ROLHA_CAP, 8, magazine capacity in corks (>=1)
CNT_W, 4, width of cork counter; must satisfy 2^CNT_W > ROLHA_CAP
LOW_LEVEL, 2, rolha_baixa asserts when cork count <= LOW_LEVEL
TOTAL_W, 16, width of sealed-bottle total counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets immediately)
garrafa  in  N_CH  bottle present at head i
pos  in  N_CH  bottle positioned under head i
recarga  in  1  magazine reload request, level-sampled each cycle
ve  out  N_CH  seal actuator for head i
done  out  N_CH  one-cycle pulse, seal of head i completed
alarme  out  N_CH  head i in alarm
alarme_geral  out  1  OR of alarme
rolhas  out  CNT_W  corks remaining
rolha_baixa  out  1  rolhas <= LOW_LEVEL
vedadas  out  TOTAL_W  total completed seals, wraps modulo 2^TOTAL_W

Behaviour:
- Reset (reset==0, async): all heads IDLE, seal timers 0, rolhas=ROLHA_CAP, vedadas=0, ve=done=alarme=0. rolha_baixa follows rolhas. Reset mid-seal drops ve at once and does not refund the cork.
- Per-head states: IDLE, VED (sealing), FIM (done pulse), SAIDA (wait bottle exit), AL (alarm). Outputs are Moore: ve=VED, done=FIM, alarme=AL.
- Cork availability per cycle: disp = recarga ? ROLHA_CAP : rolhas.
- Request: req[i] = garrafa[i] & pos[i] & (state in IDLE or AL).
- Grant is fixed priority, lowest index first. req[i] is granted iff the count of lower-index requests is < disp.
- Counter update: rolhas_next = disp - number of grants. A reload in the same cycle as grants is not lost; grants are counted against ROLHA_CAP.
- IDLE:
  - granted -> VED, timer loaded.
  - req but not granted -> AL.
  - disp==0 (even without a bottle) -> AL.
  - otherwise stay IDLE.
- VED:
  - ve high for exactly SEAL_CYCLES consecutive cycles, then -> FIM.
  - garrafa[i]==0 or pos[i]==0 in any VED cycle -> AL next cycle; the cork stays consumed and no done pulse is issued.
- FIM: done[i]=1 for exactly one cycle; vedadas increments by the number of heads in FIM that cycle; -> SAIDA unconditionally.
- SAIDA: wait until garrafa[i]==0, then -> IDLE. This prevents double-sealing the same bottle.
- AL:
  - granted -> VED.
  - disp>0 and garrafa[i]==0 -> IDLE.
  - otherwise stay AL.
- Latency: bottle positioned at edge k (granted) -> ve high from k+1 through k+SEAL_CYCLES -> done at k+SEAL_CYCLES+1.
- Boundaries:
  - Empty magazine alarms every IDLE head.
  - Partial availability grants only the lowest-index requesters; the rest go to AL.
  - rolhas never underflows and never exceeds ROLHA_CAP.
  - vedadas wraps from all-ones to the low bits of the increment.

Test Plan:
- Reset, N_CH=2, SEAL_CYCLES=3, ROLHA_CAP=4, LOW_LEVEL=1: expect rolhas=4, outputs 0. Set garrafa=01, pos=01: ve[0] high 3 cycles, done[0] 1-cycle pulse, rolhas=3, vedadas=1. Head0 then sits in SAIDA until garrafa[0]=0.
- Both heads request with rolhas=1: head0 enters VED, head1 goes to AL; rolhas=0. Next cycle all IDLE heads alarm; alarme_geral=1, rolha_baixa=1.
- With head1 in AL, rolhas=0, pulse recarga while garrafa[1]&pos[1]=1: head1 is granted and enters VED; rolhas=ROLHA_CAP-1=3; alarme[1] clears.
- Drop pos[0] during the second VED cycle: ve[0] falls and head0 enters AL next cycle; no done[0]; cork not refunded; vedadas unchanged.
- Assert reset=0 asynchronously mid-VED: ve drops without a clock edge; rolhas=4, vedadas=0 after release.
- Preload vedadas near 2^TOTAL_W-1 (TOTAL_W=2 build) and complete 2 simultaneous seals: vedadas wraps 3->1.

Source files
------------

// File: rtl/vedacao_multicanal_if.sv
// Sensor/actuator bundle between the conveyor, the sealing heads and the cork magazine.
// Carries no state and adds no latency.
// No backpressure: the sensors are level inputs and the actuator outputs are Moore flags.
interface vedacao_multicanal_if #(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 16
);
    logic [N_CH-1:0]    garrafa;
    logic [N_CH-1:0]    pos;
    logic               recarga;
    logic [N_CH-1:0]    ve;
    logic [N_CH-1:0]    done;
    logic [N_CH-1:0]    alarme;
    logic               alarme_geral;
    logic [CNT_W-1:0]   rolhas;
    logic               rolha_baixa;
    logic [TOTAL_W-1:0] vedadas;

    modport master (
        output garrafa, pos, recarga,
        input  ve, done, alarme, alarme_geral, rolhas, rolha_baixa, vedadas
    );

    modport slave (
        input  garrafa, pos, recarga,
        output ve, done, alarme, alarme_geral, rolhas, rolha_baixa, vedadas
    );
endinterface

// File: rtl/vedacao_multicanal.sv
// N_CH sealing heads sharing one cork magazine, with fixed-priority cork grant and per-head alarm.
// Grant at edge k -> ve high k+1..k+SEAL_CYCLES -> done at k+SEAL_CYCLES+1; rolhas/vedadas update one edge after the event.
// No backpressure: heads that cannot get a cork drop into alarm and retry while their bottle stays put.
module vedacao_multicanal #(
    parameter int N_CH        = 2,
    parameter int SEAL_CYCLES = 3,
    parameter int ROLHA_CAP   = 8,
    parameter int CNT_W       = 4,
    parameter int LOW_LEVEL   = 2,
    parameter int TOTAL_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    vedacao_multicanal_if.slave   bus
);
    localparam int TMR_W = $clog2(SEAL_CYCLES + 1);
    localparam int ACC_W = CNT_W + $clog2(N_CH + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_VED, S_FIM, S_SAIDA, S_AL} state_t;

    state_t             r_state   [N_CH];
    state_t             w_state_nx[N_CH];
    logic [TMR_W-1:0]   r_tmr     [N_CH];
    logic [TMR_W-1:0]   w_tmr_nx  [N_CH];
    logic [CNT_W-1:0]   r_rolhas;
    logic [CNT_W-1:0]   w_rolhas_nx;
    logic [CNT_W-1:0]   w_disp;
    logic [TOTAL_W-1:0] r_vedadas;
    logic [TOTAL_W-1:0] w_vedadas_nx;
    logic [TOTAL_W-1:0] w_nfim;
    logic [N_CH-1:0]    w_req;
    logic [N_CH-1:0]    w_gnt;
    logic [ACC_W-1:0]   w_nreq;
    logic [ACC_W-1:0]   w_ngnt;

    // Cork arbitration: a reload makes the full magazine available this cycle, lowest head index wins.
    always_comb begin
        w_disp = bus.recarga ? CNT_W'(ROLHA_CAP) : r_rolhas;
        w_req  = '0;
        w_gnt  = '0;
        w_nreq = '0;
        w_ngnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_req[i] = bus.garrafa[i] & bus.pos[i] &
                       ((r_state[i] == S_IDLE) || (r_state[i] == S_AL));
            if (w_req[i]) begin
                w_gnt[i] = (w_nreq < ACC_W'(w_disp));
                w_nreq   = w_nreq + ACC_W'(1);
                if (w_gnt[i]) begin
                    w_ngnt = w_ngnt + ACC_W'(1);
                end
            end
        end
        w_rolhas_nx = CNT_W'(ACC_W'(w_disp) - w_ngnt);
    end

    // Per-head next state and seal timer, plus the completed-seal total.
    always_comb begin
        w_nfim = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_state_nx[i] = r_state[i];
            w_tmr_nx[i]   = r_tmr[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_gnt[i]) begin
                        w_state_nx[i] = S_VED;
                        w_tmr_nx[i]   = TMR_W'(SEAL_CYCLES);
                    end else if (w_req[i] || (w_disp == '0)) begin
                        w_state_nx[i] = S_AL;
                    end
                end
                S_VED: begin
                    // Losing the bottle aborts the seal; the cork is already spent.
                    if (!(bus.garrafa[i] && bus.pos[i])) begin
                        w_state_nx[i] = S_AL;
                        w_tmr_nx[i]   = '0;
                    end else if (r_tmr[i] <= TMR_W'(1)) begin
                        w_state_nx[i] = S_FIM;
                        w_tmr_nx[i]   = '0;
                    end else begin
                        w_tmr_nx[i] = r_tmr[i] - TMR_W'(1);
                    end
                end
                S_FIM: begin
                    w_state_nx[i] = S_SAIDA;
                    w_nfim        = w_nfim + TOTAL_W'(1);
                end
                S_SAIDA: begin
                    // Hold until the sealed bottle leaves so it is never sealed twice.
                    if (!bus.garrafa[i]) begin
                        w_state_nx[i] = S_IDLE;
                    end
                end
                S_AL: begin
                    if (w_gnt[i]) begin
                        w_state_nx[i] = S_VED;
                        w_tmr_nx[i]   = TMR_W'(SEAL_CYCLES);
                    end else if ((w_disp != '0) && !bus.garrafa[i]) begin
                        w_state_nx[i] = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx[i] = S_IDLE;
                    w_tmr_nx[i]   = '0;
                end
            endcase
        end
        w_vedadas_nx = r_vedadas + w_nfim;
    end

    // State, timers, magazine level and seal total; reset refills the magazine without refunding anything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_tmr[i]   <= '0;
            end
            r_rolhas  <= CNT_W'(ROLHA_CAP);
            r_vedadas <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_tmr[i]   <= w_tmr_nx[i];
            end
            r_rolhas  <= w_rolhas_nx;
            r_vedadas <= w_vedadas_nx;
        end
    end

    // Moore decode of the head states onto the actuator and status outputs.
    always_comb begin
        bus.ve     = '0;
        bus.done   = '0;
        bus.alarme = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.ve[i]     = (r_state[i] == S_VED);
            bus.done[i]   = (r_state[i] == S_FIM);
            bus.alarme[i] = (r_state[i] == S_AL);
        end
    end

    assign bus.alarme_geral = |bus.alarme;
    assign bus.rolhas       = r_rolhas;
    assign bus.rolha_baixa  = (r_rolhas <= CNT_W'(LOW_LEVEL));
    assign bus.vedadas      = r_vedadas;

endmodule

// File: tb/tb_vedacao_multicanal.sv
// Bench for vedacao_multicanal: directed walkthrough of the sealing scenarios, then random sensor traffic.
// Every cycle all outputs are compared with a cycle-level reference model of the heads and magazine.
// Small build (2 heads, 4 corks, 2-bit total) so empty magazine and total wrap are reached quickly.
module tb_vedacao_multicanal;
    localparam int N    = 2;
    localparam int SEAL = 3;
    localparam int CAP  = 4;
    localparam int CW   = 3;
    localparam int LOW  = 1;
    localparam int TW   = 2;

    localparam int MD_IDLE  = 0;
    localparam int MD_SEAL  = 1;
    localparam int MD_DONE  = 2;
    localparam int MD_EXIT  = 3;
    localparam int MD_ALARM = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    int   m_mode  [N];
    int   m_cycles[N];
    int   m_rolhas;
    int   m_ved;

    vedacao_multicanal_if #(.N_CH(N), .CNT_W(CW), .TOTAL_W(TW)) bus ();

    vedacao_multicanal #(
        .N_CH(N), .SEAL_CYCLES(SEAL), .ROLHA_CAP(CAP),
        .CNT_W(CW), .LOW_LEVEL(LOW), .TOTAL_W(TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i]   = MD_IDLE;
            m_cycles[i] = 0;
        end
        m_rolhas = CAP;
        m_ved    = 0;
    endtask

    // One clock of the reference: corks are handed out in index order while any remain.
    task automatic model_step(input logic [N-1:0] g, input logic [N-1:0] p, input logic rc);
        int disp;
        int handed;
        int finished;
        bit req[N];
        bit gr [N];
        disp     = rc ? CAP : m_rolhas;
        handed   = 0;
        finished = 0;
        for (int i = 0; i < N; i++) begin
            req[i] = g[i] && p[i] && (m_mode[i] == MD_IDLE || m_mode[i] == MD_ALARM);
            gr[i]  = req[i] && (handed < disp);
            if (gr[i]) handed++;
            if (m_mode[i] == MD_DONE) finished++;
        end
        for (int i = 0; i < N; i++) begin
            case (m_mode[i])
                MD_IDLE: begin
                    if (gr[i]) begin m_mode[i] = MD_SEAL; m_cycles[i] = 0; end
                    else if (req[i] || disp == 0) m_mode[i] = MD_ALARM;
                end
                MD_SEAL: begin
                    if (!(g[i] && p[i])) m_mode[i] = MD_ALARM;
                    else begin
                        m_cycles[i]++;
                        if (m_cycles[i] == SEAL) m_mode[i] = MD_DONE;
                    end
                end
                MD_DONE: m_mode[i] = MD_EXIT;
                MD_EXIT: if (!g[i]) m_mode[i] = MD_IDLE;
                default: begin
                    if (gr[i]) begin m_mode[i] = MD_SEAL; m_cycles[i] = 0; end
                    else if (disp > 0 && !g[i]) m_mode[i] = MD_IDLE;
                end
            endcase
        end
        m_rolhas = disp - handed;
        m_ved    = (m_ved + finished) % (1 << TW);
    endtask

    task automatic check_model(input string where);
        int e_ve;
        int e_done;
        int e_al;
        e_ve = 0; e_done = 0; e_al = 0;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i] == MD_SEAL)  e_ve   |= (1 << i);
            if (m_mode[i] == MD_DONE)  e_done |= (1 << i);
            if (m_mode[i] == MD_ALARM) e_al   |= (1 << i);
        end
        chk({where, " ve"},           bus.ve,           e_ve);
        chk({where, " done"},         bus.done,         e_done);
        chk({where, " alarme"},       bus.alarme,       e_al);
        chk({where, " alarme_geral"}, bus.alarme_geral, (e_al != 0) ? 1 : 0);
        chk({where, " rolhas"},       bus.rolhas,       m_rolhas);
        chk({where, " rolha_baixa"},  bus.rolha_baixa,  (m_rolhas <= LOW) ? 1 : 0);
        chk({where, " vedadas"},      bus.vedadas,      m_ved);
    endtask

    task automatic step(input logic [N-1:0] g, input logic [N-1:0] p, input logic rc, input string where);
        bus.garrafa = g;
        bus.pos     = p;
        bus.recarga = rc;
        model_step(g, p, rc);
        @(posedge clk);
        #1;
        check_model(where);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic         rc;
        errors = 0;
        checks = 0;
        bus.garrafa = '0;
        bus.pos     = '0;
        bus.recarga = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #1;
        check_model("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check_model("post_reset");

        // Single seal on head 0, then the bottle lingers under the head.
        step(2'b01, 2'b01, 1'b0, "A1");
        chk("A1 ve0 high", bus.ve, 1);
        chk("A1 cork taken", bus.rolhas, 3);
        step(2'b01, 2'b01, 1'b0, "A2");
        step(2'b01, 2'b01, 1'b0, "A3");
        chk("A3 ve still high", bus.ve, 1);
        step(2'b01, 2'b01, 1'b0, "A4");
        chk("A4 done pulse", bus.done, 1);
        step(2'b01, 2'b01, 1'b0, "A5");
        chk("A5 vedadas", bus.vedadas, 1);
        step(2'b01, 2'b01, 1'b0, "A6");
        chk("A6 no reseal", bus.ve, 0);
        step(2'b00, 2'b00, 1'b0, "A7");
        for (int s = 0; s < 2; s++) begin
            repeat (5) step(2'b01, 2'b01, 1'b0, "Aloop");
            step(2'b00, 2'b00, 1'b0, "Aclr");
        end
        chk("A magazine at one", bus.rolhas, 1);

        // Both heads want the last cork: head 0 wins, head 1 alarms.
        step(2'b11, 2'b11, 1'b0, "B");
        chk("B ve", bus.ve, 1);
        chk("B alarme", bus.alarme, 2);
        chk("B rolhas empty", bus.rolhas, 0);
        chk("B alarme_geral", bus.alarme_geral, 1);
        chk("B rolha_baixa", bus.rolha_baixa, 1);

        // Reload while head 1 still waits: it is granted from the refilled magazine.
        step(2'b11, 2'b11, 1'b1, "C");
        chk("C ve both", bus.ve, 3);
        chk("C alarme cleared", bus.alarme, 0);
        chk("C rolhas after reload", bus.rolhas, 3);

        // Head 0 loses its position in its second sealing cycle.
        step(2'b11, 2'b10, 1'b0, "D");
        chk("D ve", bus.ve, 2);
        chk("D alarme0", bus.alarme, 1);
        chk("D no done", bus.done, 0);
        chk("D no refund", bus.rolhas, 3);
        chk("D vedadas kept", bus.vedadas, 3);
        step(2'b11, 2'b10, 1'b0, "D1");
        step(2'b11, 2'b10, 1'b0, "D2");
        chk("D2 done1", bus.done, 2);
        step(2'b11, 2'b10, 1'b0, "D3");
        step(2'b00, 2'b00, 1'b0, "D4");

        // Asynchronous reset in the middle of a seal.
        step(2'b01, 2'b01, 1'b0, "E");
        #2 reset = 1'b0;
        #1;
        chk("E async ve drop", bus.ve, 0);
        chk("E async rolhas", bus.rolhas, CAP);
        chk("E async vedadas", bus.vedadas, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check_model("E released");

        // Bring the total to 3, then two simultaneous seals wrap it to 1.
        for (int s = 0; s < 3; s++) begin
            repeat (5) step(2'b01, 2'b01, 1'b0, "Floop");
            step(2'b00, 2'b00, 1'b0, "Fclr");
        end
        chk("F vedadas before wrap", bus.vedadas, 3);
        step(2'b11, 2'b11, 1'b1, "F1");
        chk("F1 two grants", bus.rolhas, 2);
        step(2'b11, 2'b11, 1'b0, "F2");
        step(2'b11, 2'b11, 1'b0, "F3");
        step(2'b11, 2'b11, 1'b0, "F4");
        chk("F4 done both", bus.done, 3);
        step(2'b11, 2'b11, 1'b0, "F5");
        chk("F5 vedadas wrapped", bus.vedadas, 1);
        step(2'b00, 2'b00, 1'b0, "F6");

        // Random sensor traffic with occasional reloads; inputs held for stretches so seals can finish.
        g = '0; p = '0; rc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = N'($urandom_range(0, (1 << N) - 1));
                p = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : g;
            end
            rc = ($urandom_range(0, 9) == 0);
            step(g, p, rc, "R");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
